// File: rtl/jtag_dtm_tap_sampled.sv
// RISC-V JTAG DTM: clk-oversampled TAP with IR/IDCODE/DTMCS/DMI/BYPASS and a valid/ready DMI request port.
// Define JTAG_DTM_DMIHARDRESET_EN to let DTMCS.dmihardreset abort an outstanding DMI request.
module jtag_dtm_tap_sampled #(
  parameter int unsigned IR_W   = 5,
  parameter int unsigned ABITS  = 6,
  parameter logic [31:0] IDCODE = 32'h1E200A6D
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              jtag_TCK,
  input  logic              jtag_TMS,
  input  logic              jtag_TDI,
  output logic              jtag_TDO,
  output logic              dmi_req_valid,
  input  logic              dmi_req_ready,
  output logic [ABITS+33:0] dmi_req_data,
  input  logic              dmi_rsp_valid,
  input  logic [33:0]       dmi_rsp_data,
  output logic [IR_W-1:0]   ir_out
);
  localparam int unsigned     DR_W      = ABITS + 34;
  localparam logic [IR_W-1:0] IR_IDCODE = IR_W'(8'h01);
  localparam logic [IR_W-1:0] IR_DTMCS  = IR_W'(8'h10);
  localparam logic [IR_W-1:0] IR_DMI    = IR_W'(8'h11);
  localparam logic [1:0]      OP_BUSY   = 2'b11;

  typedef enum logic [3:0] {
    TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
  } tap_state_e;

  tap_state_e       state_q, state_d;
  logic [2:0]       sync1_q, sync1_d, sync2_q, sync2_d;
  logic             tck_prev_q, tck_prev_d;
  logic [IR_W-1:0]  ir_q, ir_d;
  logic [DR_W-1:0]  sr_q, sr_d;
  logic             tdo_q, tdo_d;
  logic             req_valid_q, req_valid_d;
  logic [DR_W-1:0]  req_data_q, req_data_d;
  logic             busy_q, busy_d;
  logic [1:0]       stat_q, stat_d;
  logic [31:0]      rsp_q, rsp_d;
  logic [ABITS-1:0] addr_q, addr_d;

  logic        tck_rise, tck_fall, tms, tdi;
  logic [1:0]  dr_op;
  logic [31:0] dtmcs_cap;
  logic        unused_rsp_op;

  assign tck_rise      = sync2_q[2] & ~tck_prev_q;
  assign tck_fall      = ~sync2_q[2] & tck_prev_q;
  assign tms           = sync2_q[1];
  assign tdi           = sync2_q[0];
  assign dr_op         = sr_q[1:0];
  assign dtmcs_cap     = {14'b0, 1'b0, 1'b0, 1'b0, 3'd1, stat_q, 6'(ABITS), 4'd1};
  assign unused_rsp_op = ^dmi_rsp_data[1:0];

  function automatic tap_state_e tap_next(input tap_state_e s, input logic m);
    case (s)
      TLR:     tap_next = m ? TLR    : RTI;
      RTI:     tap_next = m ? SEL_DR : RTI;
      SEL_DR:  tap_next = m ? SEL_IR : CAP_DR;
      CAP_DR:  tap_next = m ? EX1_DR : SH_DR;
      SH_DR:   tap_next = m ? EX1_DR : SH_DR;
      EX1_DR:  tap_next = m ? UPD_DR : PAU_DR;
      PAU_DR:  tap_next = m ? EX2_DR : PAU_DR;
      EX2_DR:  tap_next = m ? UPD_DR : SH_DR;
      UPD_DR:  tap_next = m ? SEL_DR : RTI;
      SEL_IR:  tap_next = m ? TLR    : CAP_IR;
      CAP_IR:  tap_next = m ? EX1_IR : SH_IR;
      SH_IR:   tap_next = m ? EX1_IR : SH_IR;
      EX1_IR:  tap_next = m ? UPD_IR : PAU_IR;
      PAU_IR:  tap_next = m ? EX2_IR : PAU_IR;
      EX2_IR:  tap_next = m ? UPD_IR : SH_IR;
      UPD_IR:  tap_next = m ? SEL_DR : RTI;
      default: tap_next = TLR;
    endcase
  endfunction

  // Capture/shift on TCK rise, TDO and update on TCK fall, DMI handshake every clk.
  always_comb begin
    sync1_d     = {jtag_TCK, jtag_TMS, jtag_TDI};
    sync2_d     = sync1_q;
    tck_prev_d  = sync2_q[2];
    state_d     = state_q;
    ir_d        = ir_q;
    sr_d        = sr_q;
    tdo_d       = tdo_q;
    req_valid_d = req_valid_q;
    req_data_d  = req_data_q;
    busy_d      = busy_q;
    stat_d      = stat_q;
    rsp_d       = rsp_q;
    addr_d      = addr_q;

    if (req_valid_q && dmi_req_ready) req_valid_d = 1'b0;
    if (dmi_rsp_valid && busy_q) begin
      busy_d = 1'b0;
      rsp_d  = dmi_rsp_data[33:2];
    end

    if (tck_rise) begin
      state_d = tap_next(state_q, tms);
      case (state_q)
        CAP_IR: sr_d = DR_W'(IR_IDCODE);
        CAP_DR: begin
          case (ir_q)
            IR_IDCODE: sr_d = DR_W'(IDCODE);
            IR_DTMCS:  sr_d = DR_W'(dtmcs_cap);
            IR_DMI:    sr_d = {addr_q, rsp_q, busy_q ? OP_BUSY : stat_q};
            default:   sr_d = '0;
          endcase
        end
        SH_IR: sr_d = {{(DR_W-IR_W){1'b0}}, tdi, sr_q[IR_W-1:1]};
        SH_DR: begin
          case (ir_q)
            IR_IDCODE, IR_DTMCS: sr_d = {{(DR_W-32){1'b0}}, tdi, sr_q[31:1]};
            IR_DMI:              sr_d = {tdi, sr_q[DR_W-1:1]};
            default:             sr_d = {{(DR_W-1){1'b0}}, tdi};
          endcase
        end
        default: ;
      endcase
    end

    if (tck_fall) begin
      tdo_d = (state_q == SH_IR || state_q == SH_DR) ? sr_q[0] : 1'b0;
      if (state_q == UPD_IR) ir_d = sr_q[IR_W-1:0];
      // A new request only when idle and no sticky error; a request while busy latches busy.
      if (state_q == UPD_DR && ir_q == IR_DMI && (dr_op == 2'd1 || dr_op == 2'd2)) begin
        if (busy_q) begin
          stat_d = OP_BUSY;
        end else if (stat_q == 2'd0) begin
          req_data_d  = sr_q;
          req_valid_d = 1'b1;
          busy_d      = 1'b1;
          addr_d      = sr_q[DR_W-1:34];
        end
      end
      if (state_q == UPD_DR && ir_q == IR_DTMCS) begin
        if (sr_q[16]) stat_d = 2'd0;
`ifdef JTAG_DTM_DMIHARDRESET_EN
        if (sr_q[17]) begin
          busy_d      = 1'b0;
          req_valid_d = 1'b0;
          stat_d      = 2'd0;
          rsp_d       = rsp_q;
        end
`endif
      end
    end

    if (state_q == TLR) ir_d = IR_IDCODE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      tck_prev_q  <= 1'b0;
      state_q     <= TLR;
      ir_q        <= IR_IDCODE;
      sr_q        <= '0;
      tdo_q       <= 1'b0;
      req_valid_q <= 1'b0;
      req_data_q  <= '0;
      busy_q      <= 1'b0;
      stat_q      <= 2'd0;
      rsp_q       <= '0;
      addr_q      <= '0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      tck_prev_q  <= tck_prev_d;
      state_q     <= state_d;
      ir_q        <= ir_d;
      sr_q        <= sr_d;
      tdo_q       <= tdo_d;
      req_valid_q <= req_valid_d;
      req_data_q  <= req_data_d;
      busy_q      <= busy_d;
      stat_q      <= stat_d;
      rsp_q       <= rsp_d;
      addr_q      <= addr_d;
    end
  end

  assign jtag_TDO      = tdo_q;
  assign dmi_req_valid = req_valid_q;
  assign dmi_req_data  = req_data_q;
  assign ir_out        = ir_q;

endmodule

// File: tb/tb_jtag_dtm_tap_sampled.sv
// Randomized bench for jtag_dtm_tap_sampled: JTAG scans checked against a transaction-level DTM model.
module tb_jtag_dtm_tap_sampled;
  localparam int unsigned     IR_W      = 5;
  localparam int unsigned     ABITS     = 6;
  localparam int unsigned     DR_W      = ABITS + 34;
  localparam logic [31:0]     IDCODE    = 32'h1E200A6D;
  localparam int unsigned     TCK_HALF  = 50;
  localparam logic [IR_W-1:0] IR_IDCODE = 5'h01;
  localparam logic [IR_W-1:0] IR_DTMCS  = 5'h10;
  localparam logic [IR_W-1:0] IR_DMI    = 5'h11;

  logic             clk;
  logic             rst_n;
  logic             jtag_TCK, jtag_TMS, jtag_TDI, jtag_TDO;
  logic             dmi_req_valid, dmi_req_ready, dmi_rsp_valid;
  logic [DR_W-1:0]  dmi_req_data;
  logic [33:0]      dmi_rsp_data;
  logic [IR_W-1:0]  ir_out;

  int n_checks = 0;
  int n_fail   = 0;

  // Transaction-level view of the DTM
  logic             m_busy;
  logic [1:0]       m_stat;
  logic [31:0]      m_rsp;
  logic [ABITS-1:0] m_addr;
  logic [IR_W-1:0]  m_ir;

  jtag_dtm_tap_sampled #(.IR_W(IR_W), .ABITS(ABITS), .IDCODE(IDCODE)) dut (
    .clk(clk), .rst_n(rst_n),
    .jtag_TCK(jtag_TCK), .jtag_TMS(jtag_TMS), .jtag_TDI(jtag_TDI), .jtag_TDO(jtag_TDO),
    .dmi_req_valid(dmi_req_valid), .dmi_req_ready(dmi_req_ready), .dmi_req_data(dmi_req_data),
    .dmi_rsp_valid(dmi_rsp_valid), .dmi_rsp_data(dmi_rsp_data), .ir_out(ir_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: run did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tck(input logic tms, input logic tdi, output logic tdo);
    jtag_TMS = tms;
    jtag_TDI = tdi;
    tdo      = jtag_TDO;
    jtag_TCK = 1'b1;
    #TCK_HALF;
    jtag_TCK = 1'b0;
    #TCK_HALF;
  endtask

  task automatic move(input logic tms);
    logic d;
    tck(tms, 1'b0, d);
  endtask

  // Full scan from Run-Test/Idle back to Run-Test/Idle
  task automatic scan(input logic is_ir, input logic [63:0] din, input int len, output logic [63:0] dout);
    logic b;
    dout = '0;
    move(1'b1);
    if (is_ir) move(1'b1);
    move(1'b0);
    move(1'b0);
    for (int i = 0; i < len; i++) begin
      tck(i == len - 1, din[i], b);
      dout[i] = b;
    end
    move(1'b1);
    move(1'b0);
  endtask

  function automatic logic [63:0] dmi_expect();
    logic [1:0] op;
    op = m_busy ? 2'b11 : m_stat;
    return 64'({m_addr, m_rsp, op});
  endfunction

  function automatic logic [63:0] dtmcs_expect();
    return 64'(32'h1000 | (32'(m_stat) << 10) | (32'(ABITS) << 4) | 32'h1);
  endfunction

  task automatic ir_set(input logic [IR_W-1:0] code);
    logic [63:0] d;
    scan(1'b1, 64'(code), IR_W, d);
    check_eq("ir_capture", d, 64'h1);
    m_ir = code;
    check_eq("ir_out", 64'(ir_out), 64'(code));
  endtask

  task automatic wait_valid();
    int t = 0;
    while (dmi_req_valid !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
  endtask

  task automatic handshake(input logic [DR_W-1:0] exp, input int delay);
    wait_valid();
    check_eq("req_valid", 64'(dmi_req_valid), 64'h1);
    check_eq("req_data", 64'(dmi_req_data), 64'(exp));
    repeat (delay) begin
      @(negedge clk);
      check_eq("req_hold", 64'({dmi_req_valid, dmi_req_data}), 64'({1'b1, exp}));
    end
    dmi_req_ready = 1'b1;
    @(negedge clk);
    dmi_req_ready = 1'b0;
    check_eq("req_drop", 64'(dmi_req_valid), 64'h0);
  endtask

  task automatic dmi_access(input logic [ABITS-1:0] addr, input logic [31:0] data,
                            input logic [1:0] op, input int delay);
    logic [DR_W-1:0] din;
    logic [63:0]     dout, exp;
    din = {addr, data, op};
    if (m_ir != IR_DMI) ir_set(IR_DMI);
    exp = dmi_expect();
    scan(1'b0, 64'(din), DR_W, dout);
    check_eq("dmi_capture", dout, exp);
    if ((op == 2'd1 || op == 2'd2) && !m_busy && m_stat == 2'd0) begin
      m_busy = 1'b1;
      m_addr = addr;
      handshake(din, delay);
    end else begin
      if ((op == 2'd1 || op == 2'd2) && m_busy) m_stat = 2'b11;
      repeat (4) @(negedge clk);
      check_eq("no_req", 64'(dmi_req_valid), 64'h0);
    end
  endtask

  task automatic dtmcs_access(input logic [31:0] w);
    logic [63:0] dout, exp;
    if (m_ir != IR_DTMCS) ir_set(IR_DTMCS);
    exp = dtmcs_expect();
    scan(1'b0, 64'(w), 32, dout);
    check_eq("dtmcs_capture", dout, exp);
    if (w[16]) m_stat = 2'd0;
`ifdef JTAG_DTM_DMIHARDRESET_EN
    if (w[17]) begin
      m_busy = 1'b0;
      m_stat = 2'd0;
    end
`endif
  endtask

  task automatic rsp(input logic [31:0] data, input logic [1:0] op);
    @(negedge clk);
    dmi_rsp_valid = 1'b1;
    dmi_rsp_data  = {data, op};
    @(negedge clk);
    dmi_rsp_valid = 1'b0;
    dmi_rsp_data  = '0;
    if (m_busy) begin
      m_busy = 1'b0;
      m_rsp  = data;
    end
  endtask

  task automatic bypass(input logic [IR_W-1:0] code, input logic [7:0] pat);
    logic [63:0] dout;
    ir_set(code);
    scan(1'b0, 64'(pat), 8, dout);
    check_eq("bypass", dout, 64'({pat[6:0], 1'b0}));
  endtask

  task automatic model_reset();
    m_busy = 1'b0;
    m_stat = 2'd0;
    m_rsp  = '0;
    m_addr = '0;
    m_ir   = IR_IDCODE;
  endtask

  initial begin
    logic [63:0]     d, exp;
    logic [IR_W-1:0] code;
    logic [DR_W-1:0] din;

    rst_n = 1'b0;
    jtag_TCK = 1'b0; jtag_TMS = 1'b1; jtag_TDI = 1'b0;
    dmi_req_ready = 1'b0; dmi_rsp_valid = 1'b0; dmi_rsp_data = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_eq("rst_tdo", 64'(jtag_TDO), 64'h0);
    check_eq("rst_valid", 64'(dmi_req_valid), 64'h0);
    check_eq("rst_data", 64'(dmi_req_data), 64'h0);
    check_eq("rst_ir", 64'(ir_out), 64'h1);
    rst_n = 1'b1;
    @(negedge clk);

    // IDCODE straight out of Test-Logic-Reset and again after an explicit IR load
    repeat (8) move(1'b1);
    move(1'b0);
    check_eq("tlr_ir", 64'(ir_out), 64'h1);
    scan(1'b0, 64'($urandom), 32, d);
    check_eq("idcode_tlr", d, 64'(IDCODE));
    ir_set(IR_IDCODE);
    scan(1'b0, 64'($urandom), 32, d);
    check_eq("idcode_ir", d, 64'(IDCODE));
    dtmcs_access(32'h0);

    // Write request held for 3 clk, then response and readback
    dmi_access(6'h10, 32'h0, 2'b10, 3);
    rsp(32'h0000_0C82, 2'b00);
    dmi_access(6'h11, 32'h0, 2'b00, 0);

    // Busy while outstanding, sticky until dmireset
    dmi_access(6'($urandom), $urandom, 2'd1, 1);
    dmi_access(6'($urandom), $urandom, 2'd2, 0);
    dmi_access(6'($urandom), $urandom, 2'd0, 0);
    rsp($urandom, 2'($urandom));
    dmi_access(6'($urandom), $urandom, 2'd0, 0);
    dtmcs_access(32'h0001_0000);
    dmi_access(6'($urandom), $urandom, 2'd0, 0);

    // Test-Logic-Reset does not cancel an outstanding request
    dmi_access(6'($urandom), $urandom, 2'd1, 2);
    repeat (5) move(1'b1);
    m_ir = IR_IDCODE;
    move(1'b0);
    check_eq("tlr_ir_busy", 64'(ir_out), 64'h1);
    rsp($urandom, 2'($urandom));
    dmi_access(6'($urandom), $urandom, 2'd0, 0);

    bypass(5'h1F, 8'hA5);

    for (int it = 0; it < 10; it++) begin
      int unsigned act;
      act = $urandom_range(5);
      if (m_busy && $urandom_range(1) == 1) rsp($urandom, 2'($urandom));
      else if (!m_busy && $urandom_range(3) == 0) rsp($urandom, 2'($urandom));
      if (act <= 3) begin
        dmi_access(6'($urandom), $urandom, 2'($urandom), int'($urandom_range(4)));
      end else if (act == 4) begin
        dtmcs_access({14'($urandom), 2'($urandom), 16'($urandom)});
      end else begin
        do code = 5'($urandom); while (code == IR_IDCODE || code == IR_DTMCS || code == IR_DMI);
        bypass(code, 8'($urandom));
      end
    end

    // Asynchronous reset in the middle of a DR shift with a request pending
    if (m_busy) rsp($urandom, 2'($urandom));
    if (m_stat != 2'd0) dtmcs_access(32'h0001_0000);
    if (m_ir != IR_DMI) ir_set(IR_DMI);
    din = {6'($urandom), 32'($urandom), 2'd1};
    exp = dmi_expect();
    scan(1'b0, 64'(din), DR_W, d);
    check_eq("rst_pre_capture", d, exp);
    wait_valid();
    check_eq("rst_pre_valid", 64'(dmi_req_valid), 64'h1);
    move(1'b1); move(1'b0); move(1'b0); move(1'b0); move(1'b0);
    jtag_TCK = 1'b1;
    #20;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_tdo", 64'(jtag_TDO), 64'h0);
    check_eq("midrst_valid", 64'(dmi_req_valid), 64'h0);
    check_eq("midrst_data", 64'(dmi_req_data), 64'h0);
    check_eq("midrst_ir", 64'(ir_out), 64'h1);
    jtag_TCK = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    move(1'b0);
    dmi_access(6'($urandom), $urandom, 2'd0, 0);
    dtmcs_access(32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
